div_unit: RTL

//   Iterative 32-bit restoring divider executing MIPS DIV/DIVU; the multi-cycle

---
 rtl/div_unit_if.sv | 18 +
 rtl/div_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between EX-stage control and the iterative divider.
// The control side uses the master modport and the divider uses the slave modport.
interface div_unit_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic            SIGN;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] Q;
    logic [SIZE-1:0] R;
    logic            DZ;

    modport master (output start, SIGN, A, B, input busy, done, Q, R, DZ);
    modport slave  (input start, SIGN, A, B, output busy, done, Q, R, DZ);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU. It produces one quotient bit per cycle.
// Latency is fixed at SIZE+1 edges from the start edge to the done pulse.
module div_unit #(
    parameter int SIZE = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] dvd, dvs, rem, a_raw;
    logic            a_neg, b_neg;
    logic [SIZE-1:0] q_r, r_r;
    logic            dz_r, done_r;

    logic [SIZE:0]   rem_sh;
    logic [SIZE-1:0] rem_diff, rem_next;
    logic            qbit, accept;

    assign accept   = (state == IDLE) && bus.start && !done_r;
    assign rem_sh   = {rem, dvd[SIZE-1]};
    assign qbit     = (rem_sh >= {1'b0, dvs});
    assign rem_diff = SIZE'(rem_sh - {1'b0, dvs});
    assign rem_next = qbit ? rem_diff : rem_sh[SIZE-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Quotient bits shift into dvd as dividend bits shift out. After SIZE steps, dvd holds |Q|.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            a_raw  <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
            dz_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    a_neg <= bus.SIGN & bus.A[SIZE-1];
                    b_neg <= bus.SIGN & bus.B[SIZE-1];
                    a_raw <= bus.A;
                    dvd   <= (bus.SIGN && bus.A[SIZE-1]) ? -bus.A : bus.A;
                    dvs   <= (bus.SIGN && bus.B[SIZE-1]) ? -bus.B : bus.B;
                    rem   <= '0;
                    count <= '0;
                end
                CALC: begin
                    dvd   <= {dvd[SIZE-2:0], qbit};
                    rem   <= rem_next;
                    count <= count + 1'b1;
                end
                DONE: begin
                    done_r <= 1'b1;
                    if (dvs == '0) begin
                        q_r  <= '1;
                        r_r  <= a_raw;
                        dz_r <= 1'b1;
                    end else begin
                        q_r  <= (a_neg ^ b_neg) ? -dvd : dvd;
                        r_r  <= a_neg ? -rem : rem;
                        dz_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.Q    = q_r;
    assign bus.R    = r_r;
    assign bus.DZ   = dz_r;
endmodule
